// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing a write-port/read-port register file with 1-cycle read return.
// Optional grant/conflict statistics counters are enabled with MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int Data_width = 8,
  parameter int Addr_width = 5,
  parameter int Cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [Addr_width-1:0] addr_a,
  input  logic [Data_width-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [Data_width-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [Addr_width-1:0] addr_b,
  input  logic [Data_width-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [Data_width-1:0] rdata_b,
  output logic                  mem_wr_en,
  output logic [Addr_width-1:0] mem_wr_addr,
  output logic [Data_width-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [Addr_width-1:0] mem_rd_addr,
  input  logic [Data_width-1:0] mem_rd_data
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [Cnt_width-1:0]  stat_gnt_a,
  output logic [Cnt_width-1:0]  stat_gnt_b,
  output logic [Cnt_width-1:0]  stat_conflict
`endif
);

  logic last_win;   // 0 = A won last single grant, 1 = B
  logic rd_pend;
  logic rd_owner;   // 0 = A, 1 = B

  logic dual;
  logic tie;
  logic single_gnt;
  logic rd_gnt_a;
  logic rd_gnt_b;

  // A write and a read from different requesters never collide: both ports issue.
  always_comb begin
    dual       = req_a & req_b & (we_a ^ we_b);
    tie        = req_a & req_b & ~dual;
    gnt_a      = rst & req_a & (~tie | last_win);
    gnt_b      = rst & req_b & (~tie | ~last_win);
    single_gnt = gnt_a ^ gnt_b;
    rd_gnt_a   = gnt_a & ~we_a;
    rd_gnt_b   = gnt_b & ~we_b;
  end

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (gnt_a && we_a) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = addr_a;
      mem_wr_data = wdata_a;
    end else if (gnt_b && we_b) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = addr_b;
      mem_wr_data = wdata_b;
    end
  end

  always_comb begin
    mem_rd_en   = rd_gnt_a | rd_gnt_b;
    mem_rd_addr = '0;
    if (rd_gnt_a) mem_rd_addr = addr_a;
    else if (rd_gnt_b) mem_rd_addr = addr_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_win <= 1'b1;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (single_gnt) last_win <= gnt_b;
      rd_pend <= rd_gnt_a | rd_gnt_b;
      if (rd_gnt_a || rd_gnt_b) rd_owner <= rd_gnt_b;
    end
  end

  always_comb begin
    rvalid_a = rd_pend & ~rd_owner;
    rvalid_b = rd_pend & rd_owner;
    rdata_a  = rvalid_a ? mem_rd_data : '0;
    rdata_b  = rvalid_b ? mem_rd_data : '0;
  end

`ifdef MEM_ARB_STATS_EN
  localparam logic [Cnt_width-1:0] CntMax = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_gnt_a    <= '0;
      stat_gnt_b    <= '0;
      stat_conflict <= '0;
    end else if (stat_clr) begin
      stat_gnt_a    <= '0;
      stat_gnt_b    <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt_a && stat_gnt_a != CntMax) stat_gnt_a <= stat_gnt_a + 1'b1;
      if (gnt_b && stat_gnt_b != CntMax) stat_gnt_b <= stat_gnt_b + 1'b1;
      if (tie && stat_conflict != CntMax) stat_conflict <= stat_conflict + 1'b1;
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares one dual-port register-file memory (separate write and read ports, single clock, 1-cycle registered read) between requesters A and B.
- Accepts read/write commands with a req/gnt handshake and drives the memory strobes, addresses and write data.
- Routes returned read data to the issuing requester with a one-cycle rvalid pulse.
- Sits between the memory array and two client blocks, e.g. a producer/consumer pair.

Parameters:
- Data_width, 8, data bus width.
- Addr_width, 5, memory address width (depth 2**Addr_width).
- Cnt_width, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous active-low reset.
- req_a  input  1  A command request; held with command stable until gnt_a.
- we_a  input  1  A command type: 1 = write, 0 = read.
- addr_a  input  Addr_width  A address.
- wdata_a  input  Data_width  A write data.
- gnt_a  output  1  A command accepted this cycle (combinational).
- rvalid_a  output  1  A read data valid (registered pulse).
- rdata_a  output  Data_width  A read data.
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as A, for B.
- mem_wr_en  output  1  memory write strobe.
- mem_wr_addr  output  Addr_width  memory write address.
- mem_wr_data  output  Data_width  memory write data.
- mem_rd_en  output  1  memory read strobe.
- mem_rd_addr  output  Addr_width  memory read address.
- mem_rd_data  input  Data_width  memory registered read data, valid the cycle after mem_rd_en.

Behaviour:
- State: last_win (1 bit: 0 = A, 1 = B), rd_pend (1 bit), rd_owner (1 bit).
- Reset (rst = 0, asynchronous):
  - last_win = B, so A wins the first tie.
  - rd_pend = 0, rvalid_a = rvalid_b = 0.
  - An in-flight read is discarded; no rvalid is produced after reset.
  - gnt_* and mem strobes are combinational and therefore 0 whenever req_a = req_b = 0.
- Grant rules (combinational, same cycle as req):
  - Only one requester asserts req: it is granted.
  - Both request, one write and one read: dual issue. Both are granted; the writer drives the write port and the reader drives the read port. last_win is unchanged.
  - Both request, same type: round robin. Grant the requester that is not last_win.
- last_win update: on each single grant, last_win takes the granted requester.
- Memory drive:
  - Granted write: mem_wr_en = 1, with the write address and data from the granted requester.
  - Granted read: mem_rd_en = 1, with the read address from the granted requester.
  - Ungranted port: enable 0, address and data driven 0.
- Read return:
  - On a read grant, rd_pend <= 1 and rd_owner <= the granted requester; otherwise rd_pend <= 0.
  - When rd_pend = 1: rvalid_<owner> = 1 and rdata_<owner> = mem_rd_data. The other requester's rdata is 0.
  - When rd_pend = 0: rvalid_* = 0 and rdata_* = 0.
  - Fixed read latency of 1 cycle after gnt. Back-to-back reads give back-to-back rvalid pulses.
- Same-address write and read in one dual-issue cycle: the read returns the pre-write contents.
- Throughput: up to 1 write plus 1 read per cycle. No requester waits more than 1 cycle under round robin.
- No back-pressure on rvalid: clients must accept read data when it is presented.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined, the block adds:
  - Input stat_clr.
  - Outputs stat_gnt_a, stat_gnt_b, stat_conflict, each Cnt_width wide, reset to 0.
- Counter behaviour:
  - stat_gnt_a / stat_gnt_b increment on each gnt_a / gnt_b.
  - stat_conflict increments on each cycle where both requesters asserted req and only one was granted.
  - All counters saturate at all-ones.
  - stat_clr = 1 zeroes all counters synchronously; clear has priority over increment.
- Undefined: the stat ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset, then A writes addr 3 = 0x5A, then A reads addr 3 -> gnt_a in each request cycle; rvalid_a = 1 and rdata_a = 0x5A one cycle after the read grant; rvalid_b stays 0.
- A and B both read continuously for 4 cycles after reset -> grants alternate A, B, A, B; rvalid pulses alternate A, B, A, B, each one cycle later.
- Same cycle: A writes addr 7 = 0x11 and B reads addr 7, where addr 7 previously held 0x22 -> both granted; rdata_b = 0x22 next cycle; a later B read of addr 7 returns 0x11.
- Read of addr 0 granted to B, rst pulsed low in the following cycle -> no rvalid_b; all rvalid = 0 and no grants while rst = 0; A wins the first tie after release.
- With MEM_ARB_STATS_EN: 5 cycles of both requesters writing -> stat_gnt_a = 3, stat_gnt_b = 2, stat_conflict = 5; stat_clr = 1 for one cycle -> all counters read 0 next cycle.
